// File: rtl/vec_pair_loader.sv
// Operand pair loader: streams (a,b) pairs into the compute block's memories,
// then issues start and waits for done before taking the next vector.
module vec_pair_loader #(
    parameter int DW = 32,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_a,
    input  logic [DW-1:0] s_b,
    input  logic          s_last,
    output logic          we,
    output logic [AW-1:0] index,
    output logic [DW-1:0] a_data,
    output logic [DW-1:0] b_data,
    output logic [31:0]   n,
    output logic          start,
    input  logic          done,
    output logic          busy,
    output logic [AW:0]   count,
    output logic          ovf
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FIRE,
        WAIT
    } state_t;

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    state_t        state;
    state_t        state_nxt;
    logic          xfer;
    logic          full;
    logic [AW-1:0] slot;
    logic [AW:0]   count_nxt;

    always_comb begin
        state_nxt = state;
        xfer      = s_valid && s_ready;
        slot      = count[AW-1:0];
        count_nxt = count + 1'b1;
        if (state == IDLE) begin
            slot      = '0;
            count_nxt = (AW+1)'(1);
        end
        full = (count_nxt == DEPTH);
        case (state)
            IDLE, LOAD: begin
                if (xfer) begin
                    state_nxt = (s_last || full) ? FIRE : LOAD;
                end
            end
            FIRE: state_nxt = WAIT;
            // start is high only in the first WAIT cycle, masking a stale done
            WAIT: begin
                if (done && !start) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            s_ready <= 1'b0;
            we      <= 1'b0;
            index   <= '0;
            a_data  <= '0;
            b_data  <= '0;
            n       <= '0;
            start   <= 1'b0;
            count   <= '0;
            ovf     <= 1'b0;
        end else begin
            state   <= state_nxt;
            s_ready <= (state_nxt == IDLE) || (state_nxt == LOAD);
            we      <= xfer;
            start   <= (state == FIRE);
            if (xfer) begin
                index  <= slot;
                a_data <= s_a;
                b_data <= s_b;
                count  <= count_nxt;
                if (full && !s_last) begin
                    ovf <= 1'b1;
                end
            end
            if (state == FIRE) begin
                n <= 32'(count - 1'b1);
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_vec_pair_loader.sv
// Bench for vec_pair_loader: directed and random vectors scored against
// a cycle-level model of the stream/vector rules.
module tb_vec_pair_loader;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        bit            last;
    } pair_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_a;
    logic [DW-1:0] s_b;
    logic          s_last;
    logic          we;
    logic [AW-1:0] index;
    logic [DW-1:0] a_data;
    logic [DW-1:0] b_data;
    logic [31:0]   n;
    logic          start;
    logic          done;
    logic          busy;
    logic [AW:0]   count;
    logic          ovf;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    pair_t src_q[$];
    bit    pend = 1'b0;
    int    vmode = 100;
    int    done_mode = 2;

    bit            m_ready;
    bit            m_blocked;
    bit            m_ovf;
    int            m_pos;
    int            m_count;
    int            m_n;
    int            pend_n;
    int            fire_cd;
    int            wait_start;
    bit            e_we;
    bit            e_start;
    int            e_idx;
    logic [DW-1:0] e_a;
    logic [DW-1:0] e_b;

    vec_pair_loader #(.DW(DW), .AW(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_a     (s_a),
        .s_b     (s_b),
        .s_last  (s_last),
        .we      (we),
        .index   (index),
        .a_data  (a_data),
        .b_data  (b_data),
        .n       (n),
        .start   (start),
        .done    (done),
        .busy    (busy),
        .count   (count),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic push_pair(input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input bit last);
        pair_t p;
        p.a    = a;
        p.b    = b;
        p.last = last;
        src_q.push_back(p);
    endtask

    function automatic bit want_valid();
        if (vmode >= 100) return 1'b1;
        if (vmode < 0) return (cyc % 2) == 0;
        return int'($urandom_range(0, 99)) < vmode;
    endfunction

    task automatic model_clear();
        m_ready    = 1'b0;
        m_blocked  = 1'b0;
        m_ovf      = 1'b0;
        m_pos      = 0;
        m_count    = 0;
        m_n        = 0;
        pend_n     = 0;
        fire_cd    = 0;
        wait_start = 0;
        e_we       = 1'b0;
        e_start    = 1'b0;
    endtask

    // One clock cycle, entered and left on a falling edge.
    task automatic step();
        bit hs;
        chk("s_ready", 64'(s_ready), 64'(m_ready));
        chk("busy", 64'(busy), 64'((m_pos > 0) || m_blocked));
        chk("count", 64'(count), 64'(m_count));
        chk("ovf", 64'(ovf), 64'(m_ovf));
        chk("n", 64'(n), 64'(m_n));
        chk("we", 64'(we), 64'(e_we));
        chk("start", 64'(start), 64'(e_start));
        if (e_we) begin
            chk("index", 64'(index), 64'(e_idx));
            chk("a_data", 64'(a_data), 64'(e_a));
            chk("b_data", 64'(b_data), 64'(e_b));
        end
        if (!pend && src_q.size() > 0 && want_valid()) begin
            pend   = 1'b1;
            s_a    = src_q[0].a;
            s_b    = src_q[0].b;
            s_last = src_q[0].last;
        end
        s_valid = pend;
        case (done_mode)
            0:       done = ($urandom_range(0, 2) == 0);
            1:       done = 1'b1;
            default: done = 1'b0;
        endcase
        e_we    = 1'b0;
        e_start = 1'b0;
        if (fire_cd > 0) begin
            fire_cd--;
            if (fire_cd == 0) begin
                e_start    = 1'b1;
                m_n        = pend_n;
                wait_start = cyc + 1;
            end
        end
        if (m_blocked && fire_cd == 0 && done && cyc > wait_start) begin
            m_blocked = 1'b0;
        end
        hs = pend && m_ready;
        if (hs) begin
            e_we  = 1'b1;
            e_idx = m_pos;
            e_a   = s_a;
            e_b   = s_b;
            m_pos++;
            m_count = m_pos;
            if (s_last || m_pos == DEPTH) begin
                if (!s_last) m_ovf = 1'b1;
                pend_n    = m_pos - 1;
                m_pos     = 0;
                m_blocked = 1'b1;
                fire_cd   = 1;
            end
            void'(src_q.pop_front());
            pend = 1'b0;
        end
        m_ready = !m_blocked;
        @(negedge clk);
    endtask

    task automatic do_reset(input int hold);
        rst     = 1'b0;
        s_valid = 1'b0;
        done    = 1'b0;
        pend    = 1'b0;
        src_q.delete();
        #1;
        chk("rst_s_ready", 64'(s_ready), 64'(0));
        chk("rst_we", 64'(we), 64'(0));
        chk("rst_index", 64'(index), 64'(0));
        chk("rst_a_data", 64'(a_data), 64'(0));
        chk("rst_b_data", 64'(b_data), 64'(0));
        chk("rst_n", 64'(n), 64'(0));
        chk("rst_start", 64'(start), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_ovf", 64'(ovf), 64'(0));
        model_clear();
        repeat (hold) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_idle(input int budget);
        int k = 0;
        while ((src_q.size() > 0 || pend || m_blocked || m_pos > 0 ||
                fire_cd > 0) && k < budget) begin
            step();
            k++;
        end
        chk("idle_timeout", 64'(k < budget), 64'(1));
    endtask

    initial begin
        s_valid = 1'b0;
        s_a     = '0;
        s_b     = '0;
        s_last  = 1'b0;
        done    = 1'b0;
        #1;
        do_reset(3);

        // 16-pair vector, continuous valid, done held low until WAIT
        for (int i = 0; i < 16; i++) push_pair(DW'(10 * (i + 1)), DW'(i + 2), i == 15);
        vmode     = 100;
        done_mode = 2;
        repeat (24) step();
        done_mode = 1;
        run_idle(10);

        // same vector with valid on alternate cycles
        for (int i = 0; i < 16; i++) push_pair(DW'(10 * (i + 1)), DW'(i + 2), i == 15);
        vmode     = -1;
        done_mode = 0;
        run_idle(200);

        // single pair, done already high before WAIT
        push_pair(DW'($urandom), DW'($urandom), 1'b1);
        vmode     = 100;
        done_mode = 1;
        run_idle(20);

        // 17 pairs with no last, then one pair closing the next vector
        for (int i = 0; i < 17; i++) push_pair(DW'($urandom), DW'($urandom), 1'b0);
        push_pair(DW'($urandom), DW'($urandom), 1'b1);
        done_mode = 0;
        run_idle(300);

        // reset in the middle of a vector, then a fresh 3-pair vector
        do_reset(2);
        for (int i = 0; i < 5; i++) push_pair(DW'($urandom), DW'($urandom), 1'b0);
        for (int k = 0; k < 20 && src_q.size() > 0; k++) step();
        step();
        do_reset(2);
        for (int i = 0; i < 3; i++) push_pair(DW'($urandom), DW'($urandom), i == 2);
        run_idle(50);

        // input held valid throughout WAIT, released by a one-cycle done
        for (int i = 0; i < 4; i++) push_pair(DW'($urandom), DW'($urandom), i == 3);
        done_mode = 2;
        for (int k = 0; k < 30 && src_q.size() > 0; k++) step();
        push_pair(DW'(32'hCAFE_0001), DW'(32'hBEEF_0002), 1'b1);
        repeat (10) step();
        done_mode = 1;
        step();
        done_mode = 2;
        repeat (3) step();
        done_mode = 0;
        run_idle(50);

        // random vectors, some longer than the memory depth
        vmode = 70;
        for (int v = 0; v < 30; v++) begin
            int len = int'($urandom_range(1, 20));
            for (int i = 0; i < len; i++) push_pair(DW'($urandom), DW'($urandom), i == len - 1);
        end
        run_idle(5000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
